// File: rtl/ctrl_types.sv
// ctrl_types: shared sizing constants for the instruction-queue /
// decode-dispatch boundary.
//
// DISPATCH_HOLD_DEPTH is the single source of truth for the number of
// entries in the dispatch hold buffer. Both the instruction queue and
// dispatch size their credit logic from it, so they always agree.
package ctrl_types;

  localparam int DISPATCH_HOLD_DEPTH = 2;

endpackage : ctrl_types

// File: rtl/rv32i_types.sv
// rv32i_types: RISC-V Formal Interface (RVFI) retirement record carried
// alongside each instruction for formal checking and trace.
//
// rvfi_data is a packed struct, so it can be stored in plain arrays and
// compared or cleared as a single vector.
package rv32i_types;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [1:0]  mode;
    logic [1:0]  ixl;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
  } rvfi_data;

endpackage : rv32i_types

// File: rtl/dispatch_hold_buffer.sv
// dispatch_hold_buffer: small FIFO between the instruction queue and
// decode/dispatch. Dispatch back-pressure stalls only this buffer rather
// than freezing a single pipeline register.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush               empties the buffer in one cycle (push/pop that
//                       cycle are discarded)
//   in_valid/in_ready   push handshake from the instruction queue;
//                       in_ready depends on state only, never on out_ready
//   in_ctrl             control word offered
//   in_rvfi             RVFI record offered (optional build)
//   out_valid/out_ready pop handshake to dispatch
//   out_ctrl            head control word, '0 while empty
//   out_rvfi            head RVFI record, '0 while empty (optional build)
//   count               current occupancy, 0..DEPTH
//
// Build option
//   DISPATCH_HOLD_RVFI_EN  adds in_rvfi/out_rvfi and their storage. Memory
//                          fields of the record are scrubbed on push.
//
// DEPTH must be a power of two and at least 2, so the pointers wrap
// naturally at DEPTH.
module dispatch_hold_buffer
  import ctrl_types::*;
#(
  parameter int CTRL_W = 64,
  parameter int DEPTH  = DISPATCH_HOLD_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CTRL_W-1:0]            in_ctrl,
`ifdef DISPATCH_HOLD_RVFI_EN
  input  rv32i_types::rvfi_data        in_rvfi,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CTRL_W-1:0]            out_ctrl,
`ifdef DISPATCH_HOLD_RVFI_EN
  output rv32i_types::rvfi_data        out_rvfi,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_next;
  logic [CTRL_W-1:0] ctrl_mem [DEPTH];
  logic              push;
  logic              pop;

  // Readiness comes from occupancy alone, so a pop while full only frees
  // the slot for the following cycle; this keeps out_ready off the
  // in_ready timing path.
  assign in_ready  = !rst && (count != FULL_CNT);
  assign out_valid = (count != '0);

  // Flush discards any handshake presented in the same cycle.
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count_next;
    end
  end

  // NOTE: storage is deliberately not reset; the empty-state output mask
  // guarantees stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) ctrl_mem[tail] <= in_ctrl;
  end

  assign out_ctrl = out_valid ? ctrl_mem[head] : '0;

`ifdef DISPATCH_HOLD_RVFI_EN
  rv32i_types::rvfi_data rvfi_mem [DEPTH];

  // Data-memory fields are meaningless before execute, so they are zeroed
  // on the way in; everything else passes through untouched.
  function automatic rv32i_types::rvfi_data scrub_mem(input rv32i_types::rvfi_data rec);
    rv32i_types::rvfi_data s;
    s            = rec;
    s.dmem_addr  = '0;
    s.dmem_rmask = '0;
    s.dmem_wmask = '0;
    s.dmem_wdata = '0;
    s.dmem_rdata = '0;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (push) rvfi_mem[tail] <= scrub_mem(in_rvfi);
  end

  assign out_rvfi = out_valid ? rvfi_mem[head] : '0;
`endif

endmodule : dispatch_hold_buffer
